// File: rtl/hamur_siparis.sv
// Order-side controller for the dough maker: takes an order, pours flour/water/salt, starts the maker, checks its result.
// Optional pass/fail counters are enabled with `define HAMUR_SIPARIS_SAYAC_EN.
`timescale 1ns/1ps
module hamur_siparis #(
    parameter int UN_ADIM     = 8,
    parameter int SU_ADIM     = 32,
    parameter int ZAMAN_ASIMI = 15
) (
    input  logic       saat,
    input  logic       reset,
    // Order handshake: an order is taken on a rising edge where siparis_gecerli and siparis_hazir are both 1;
    // siparis_hazir does not depend on siparis_gecerli, and siparis_gecerli is ignored while busy.
    input  logic       siparis_gecerli,
    output logic       siparis_hazir,
    input  logic [1:0] hedef_kalinlik,
    input  logic       hedef_mayali,
    input  logic       hedef_tuzlu,
    output logic       basla,
    output logic [5:0] un_miktari,
    output logic [7:0] su_miktari,
    output logic [2:0] tuz_miktari,
    output logic       maya,
    input  logic [1:0] kalinlik,
    input  logic       mayali,
    input  logic       tuzlu,
    input  logic       bitti,
    output logic       sonuc_gecerli,
    output logic       sonuc_hata,
    output logic       zaman_asimi,
`ifdef HAMUR_SIPARIS_SAYAC_EN
    output logic [7:0] basarili_sayisi,
    output logic [7:0] hatali_sayisi,
`endif
    output logic [2:0] durum
);

    typedef enum logic [2:0] {
        BOS, UN_DOK, SU_DOK, TUZ_DOK, BASLA, BEKLE, KONTROL
    } durum_t;

    localparam int SW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [6:0] UN_HEDEF = 7'd40;

    durum_t          durum_q;
    logic [1:0]      h_kal;
    logic            h_maya;
    logic [7:0]      su_hedef;
    logic [2:0]      tuz_hedef;
    logic [SW-1:0]   sayac;

    // One extra bit on every step so the comparison against the target never sees a wrapped sum.
    logic [6:0]      un_sonraki;
    logic [8:0]      su_sonraki;
    logic [3:0]      tuz_sonraki;

    assign un_sonraki    = {1'b0, un_miktari} + 7'(UN_ADIM);
    assign su_sonraki    = {1'b0, su_miktari} + 9'(SU_ADIM);
    assign tuz_sonraki   = {1'b0, tuz_miktari} + 4'd1;
    assign siparis_hazir = (durum_q == BOS);
    assign durum         = durum_q;

    function automatic logic [7:0] su_tarifi(input logic [1:0] k, input logic y);
        case (k)
            2'd0:    return y ? 8'd100 : 8'd80;
            2'd1:    return y ? 8'd150 : 8'd125;
            default: return y ? 8'd255 : 8'd220;
        endcase
    endfunction

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q       <= BOS;
            h_kal         <= 2'd0;
            h_maya        <= 1'b0;
            su_hedef      <= 8'd0;
            tuz_hedef     <= 3'd0;
            sayac         <= '0;
            basla         <= 1'b0;
            un_miktari    <= 6'd0;
            su_miktari    <= 8'd0;
            tuz_miktari   <= 3'd0;
            maya          <= 1'b0;
            sonuc_gecerli <= 1'b0;
            sonuc_hata    <= 1'b0;
            zaman_asimi   <= 1'b0;
`ifdef HAMUR_SIPARIS_SAYAC_EN
            basarili_sayisi <= 8'd0;
            hatali_sayisi   <= 8'd0;
`endif
        end else begin
            basla         <= 1'b0;
            sonuc_gecerli <= 1'b0;
            sonuc_hata    <= 1'b0;
            zaman_asimi   <= 1'b0;
            case (durum_q)
                BOS: begin
                    if (siparis_gecerli) begin
                        h_kal       <= hedef_kalinlik;
                        h_maya      <= hedef_mayali;
                        su_hedef    <= su_tarifi(hedef_kalinlik, hedef_mayali);
                        tuz_hedef   <= hedef_tuzlu ? 3'd6 : 3'd2;
                        un_miktari  <= 6'd0;
                        su_miktari  <= 8'd0;
                        tuz_miktari <= 3'd0;
                        maya        <= hedef_mayali;
                        if (hedef_kalinlik == 2'd3) begin
                            durum_q       <= KONTROL;
                            sonuc_gecerli <= 1'b1;
                            sonuc_hata    <= 1'b1;
                        end else begin
                            durum_q <= UN_DOK;
                        end
                    end
                end
                UN_DOK: begin
                    if (un_sonraki >= UN_HEDEF) begin
                        un_miktari <= UN_HEDEF[5:0];
                        durum_q    <= SU_DOK;
                    end else begin
                        un_miktari <= un_sonraki[5:0];
                    end
                end
                SU_DOK: begin
                    if (su_sonraki >= {1'b0, su_hedef}) begin
                        su_miktari <= su_hedef;
                        durum_q    <= TUZ_DOK;
                    end else begin
                        su_miktari <= su_sonraki[7:0];
                    end
                end
                TUZ_DOK: begin
                    if (tuz_sonraki >= {1'b0, tuz_hedef}) begin
                        tuz_miktari <= tuz_hedef;
                        durum_q     <= BASLA;
                        basla       <= 1'b1;
                    end else begin
                        tuz_miktari <= tuz_sonraki[2:0];
                    end
                end
                BASLA: begin
                    sayac   <= '0;
                    durum_q <= BEKLE;
                end
                BEKLE: begin
                    // bitti is tested first so a reply on the last allowed cycle still counts.
                    if (bitti) begin
                        durum_q       <= KONTROL;
                        sonuc_gecerli <= 1'b1;
                        sonuc_hata    <= (kalinlik != h_kal) || (mayali != h_maya) ||
                                         (tuzlu != (tuz_miktari >= 3'd5));
                    end else if (sayac == SW'(ZAMAN_ASIMI - 1)) begin
                        durum_q       <= KONTROL;
                        sonuc_gecerli <= 1'b1;
                        sonuc_hata    <= 1'b1;
                        zaman_asimi   <= 1'b1;
                    end else begin
                        sayac <= sayac + SW'(1);
                    end
                end
                KONTROL: begin
                    durum_q <= BOS;
`ifdef HAMUR_SIPARIS_SAYAC_EN
                    if (sonuc_hata) begin
                        if (hatali_sayisi != 8'hFF) hatali_sayisi <= hatali_sayisi + 8'd1;
                    end else begin
                        if (basarili_sayisi != 8'hFF) basarili_sayisi <= basarili_sayisi + 8'd1;
                    end
`endif
                end
                default: durum_q <= BOS;
            endcase
        end
    end

endmodule

// File: doc/hamur_siparis.md
Name: hamur_siparis

Overview:
- Order-side controller for the dough maker: accepts a dough order (target thickness, yeast, salt) and selects a recipe.
- Pours ingredients incrementally onto the dough maker's input bus, then pulses basla.
- Waits for bitti, captures the dough maker's result and checks it against the order.
- Reports pass/fail; sits upstream of the dough maker and drives its entire input side.

Parameters:
- UN_ADIM, 8: flour added per cycle during pouring.
- SU_ADIM, 32: water added per cycle during pouring.
- ZAMAN_ASIMI, 15: maximum cycles spent waiting for bitti before declaring a timeout.

Ports:
- saat  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- siparis_gecerli  input  1  order valid.
- siparis_hazir  output  1  ready to accept an order.
- hedef_kalinlik  input  2  target thickness: 0, 1 or 2; 3 is invalid.
- hedef_mayali  input  1  order wants yeast.
- hedef_tuzlu  input  1  order wants salt.
- basla  output  1  start pulse to the dough maker.
- un_miktari  output  6  flour amount.
- su_miktari  output  8  water amount.
- tuz_miktari  output  3  salt amount.
- maya  output  1  yeast select.
- kalinlik  input  2  dough maker result: thickness.
- mayali  input  1  dough maker result: yeasted.
- tuzlu  input  1  dough maker result: salted.
- bitti  input  1  dough maker done.
- sonuc_gecerli  output  1  one-cycle result strobe.
- sonuc_hata  output  1  error flag, valid with sonuc_gecerli.
- zaman_asimi  output  1  timeout flag, valid with sonuc_gecerli.

Behaviour:
- Reset (reset=0, asynchronous):
  - state BOS;
  - all registered outputs 0 (basla, un_miktari, su_miktari, tuz_miktari, maya, sonuc_gecerli, sonuc_hata, zaman_asimi);
  - siparis_hazir=1.
  - A reset mid-operation aborts immediately: basla drops, and no result strobe is produced.
- States: BOS, UN_DOK, SU_DOK, TUZ_DOK, BASLA, BEKLE, KONTROL.
- siparis_hazir = (state==BOS), combinational.
- Acceptance: siparis_gecerli & siparis_hazir at a clock edge.
  - Latch the targets.
  - Clear un/su/tuz_miktari to 0.
  - Set maya=hedef_mayali.
  - Select the recipe and go to UN_DOK.
  - If hedef_kalinlik==3, go directly to KONTROL with hata forced (no pouring, no basla).
- siparis_gecerli is ignored outside BOS.
- Recipe:
  - un target is always 40.
  - su target, yeasted: k0=100, k1=150, k2=255.
  - su target, unyeasted: k0=80, k1=125, k2=220.
  - tuz target: 6 if salted, else 2.
  - All sums un*su+tuz fall strictly inside the dough maker's thickness bands (5000/10000 yeasted, 4000/8000 unyeasted).
- Pouring:
  - One step per cycle; a step that would reach or exceed the target loads the target exactly. Widths never wrap.
  - UN_DOK adds UN_ADIM per cycle; SU_DOK adds SU_ADIM per cycle; TUZ_DOK adds 1 per cycle.
  - The state advances on the cycle the target is loaded.
  - Example: un=40 takes 5 cycles; su=255 takes 8 cycles (32..224, 255).
- BASLA: basla=1 for exactly one cycle; ingredient outputs are stable; next state BEKLE.
- BEKLE:
  - Count cycles from 0.
  - On bitti=1: capture kalinlik/mayali/tuzlu, go to KONTROL.
  - If the count reaches ZAMAN_ASIMI with bitti still 0: set the timeout flag, go to KONTROL.
  - If bitti=1 on the same cycle as the limit, bitti wins (no timeout).
- KONTROL:
  - sonuc_gecerli=1 for one cycle.
  - sonuc_hata=1 if any of: invalid order, timeout, captured kalinlik≠target, mayali≠hedef_mayali, or tuzlu≠(tuz≥5).
  - zaman_asimi=1 only on timeout.
  - Next state BOS.
- Ingredient outputs and maya hold their values until the next acceptance.
- sonuc_hata and zaman_asimi are 0 whenever sonuc_gecerli=0.

Optional Feature:
- Macro: HAMUR_SIPARIS_SAYAC_EN.
- Defined: adds output ports basarili_sayisi[7:0] and hatali_sayisi[7:0].
  - basarili_sayisi increments on each strobe with hata=0; hatali_sayisi increments on each strobe with hata=1.
  - Both saturate at 255 and clear on reset.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Yeasted, k=1, salted order, with the real dough maker attached:
  - Drive un 8,16,24,32,40, then su 32,64,96,128,150, then tuz 1..6, then basla pulse.
  - Result: sonuc_gecerli with hata=0 (the dough maker returns kalinlik=1, mayali=1, tuzlu=1).
- Unyeasted, k=2, unsalted order:
  - Final un=40, su=220, tuz=2, maya=0.
  - Captured kalinlik=2, tuzlu=0, hata=0.
- hedef_kalinlik=3:
  - No basla issued.
  - sonuc_gecerli on the cycle after acceptance, with hata=1, zaman_asimi=0.
- bitti tied to 0:
  - Result after ZAMAN_ASIMI=15 cycles in BEKLE, with hata=1, zaman_asimi=1.
  - siparis_hazir=1 on the following cycle.
- Stub returns kalinlik=0 for a yeasted k=2 order:
  - hata=1, zaman_asimi=0.
  - With HAMUR_SIPARIS_SAYAC_EN defined, hatali_sayisi goes 0→1.
- Reset and busy-order handling:
  - reset=0 asserted during SU_DOK: all outputs 0 immediately, and no result strobe after release.
  - A second order with siparis_gecerli held high during BEKLE is not accepted until BOS.
